// File: rtl/ofm_addr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ofm_addr_pkg: shared state encoding, sizing and config bundle        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ofm_addr_pkg;

    localparam int OFM_SYSTOLIC_SIZE = 16;
    localparam int OFM_ADDR_W        = 22;
    localparam int OFM_DIM_W         = 9;
    localparam int OFM_CH_W          = 10;

    function automatic int calc_len_w(input int systolic_size);
        return $clog2(2 * systolic_size) + 1;
    endfunction

    localparam int OFM_GRP_W = $clog2(OFM_SYSTOLIC_SIZE) + 1;
    localparam int OFM_LEN_W = calc_len_w(OFM_SYSTOLIC_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_WAIT_TILE = 3'd2,
        ST_EMIT      = 3'd3,
        ST_ADVANCE   = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    typedef struct packed {
        logic [OFM_ADDR_W-1:0] base_addr;
        logic [OFM_DIM_W-1:0]  ofm_w;
        logic [OFM_DIM_W-1:0]  ofm_h;
        logic [OFM_CH_W-1:0]   num_ch;
        logic [OFM_GRP_W-1:0]  grp_ch;
        logic [OFM_GRP_W-1:0]  tile_w;
        logic                  upsample;
        logic [OFM_ADDR_W-1:0] addr_limit;
    } cfg_t;

endpackage
`default_nettype wire

// File: rtl/ofm_addr_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ofm_addr_accum: channel/row/column offset accumulators for OFM addr  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ofm_addr_accum
    import ofm_addr_pkg::*;
#(
    parameter int ADDR_W = OFM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              ch_step_i,
    input  logic              ch_rewind_i,
    input  logic              grp_commit_i,
    input  logic              row_step_i,
    input  logic              row_clr_i,
    input  logic              col_step_i,
    input  logic              col_clr_i,
    input  logic [ADDR_W-1:0] plane_i,
    input  logic [ADDR_W-1:0] row_inc_i,
    input  logic [ADDR_W-1:0] col_inc_i,
    output logic [ADDR_W-1:0] ch_off_o,
    output logic [ADDR_W-1:0] row_off_o,
    output logic [ADDR_W-1:0] col_off_o
);

    logic [ADDR_W-1:0] grp_off_q;
    logic [ADDR_W-1:0] ch_off_q;
    logic [ADDR_W-1:0] row_off_q;
    logic [ADDR_W-1:0] col_off_q;

    // After a group's last tile ch_off already points at the next group's first plane.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            grp_off_q <= '0;
            ch_off_q  <= '0;
            row_off_q <= '0;
            col_off_q <= '0;
        end else begin
            if (ch_step_i) begin
                ch_off_q <= ch_off_q + plane_i;
            end else if (ch_rewind_i) begin
                ch_off_q <= grp_off_q;
            end
            if (grp_commit_i) begin
                grp_off_q <= ch_off_q;
            end
            if (row_clr_i) begin
                row_off_q <= '0;
            end else if (row_step_i) begin
                row_off_q <= row_off_q + row_inc_i;
            end
            if (col_clr_i) begin
                col_off_q <= '0;
            end else if (col_step_i) begin
                col_off_q <= col_off_q + col_inc_i;
            end
        end
    end

    assign ch_off_o  = ch_off_q;
    assign row_off_o = row_off_q;
    assign col_off_o = col_off_q;

endmodule
`default_nettype wire

// File: rtl/ofm_write_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ofm_write_addr_gen: OFM RAM write-beat generator; bounds check with  |
// | OFM_ADDR_BOUNDS_CHECK_EN.                              Rev 1.0       |
// +----------------------------------------------------------------------+
module ofm_write_addr_gen
    import ofm_addr_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = OFM_SYSTOLIC_SIZE,
    parameter int ADDR_W        = OFM_ADDR_W,
    parameter int DIM_W         = OFM_DIM_W,
    parameter int CH_W          = OFM_CH_W,
    parameter int LEN_W         = calc_len_w(SYSTOLIC_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              cfg_base_addr,
    input  logic [DIM_W-1:0]               cfg_ofm_w,
    input  logic [DIM_W-1:0]               cfg_ofm_h,
    input  logic [CH_W-1:0]                cfg_num_ch,
    input  logic [$clog2(SYSTOLIC_SIZE):0] cfg_grp_ch,
    input  logic [$clog2(SYSTOLIC_SIZE):0] cfg_tile_w,
    input  logic                           cfg_upsample,
    input  logic [ADDR_W-1:0]              cfg_addr_limit,
    input  logic                           tile_valid,
    output logic                           tile_ready,
    output logic                           addr_valid,
    input  logic                           addr_ready,
    output logic [ADDR_W-1:0]              ofm_addr,
    output logic [LEN_W-1:0]               write_len,
    output logic                           addr_last,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int GRP_W = $clog2(SYSTOLIC_SIZE) + 1;

    state_e             state_q, state_d;
    cfg_t               cfg_q;
    logic [ADDR_W-1:0]  plane_q;
    logic [DIM_W-1:0]   row_q;
    logic [DIM_W-1:0]   col0_q;
    logic [CH_W-1:0]    chb_q;
    logic [GRP_W-1:0]   ch_q;
    logic               dup_q;

    logic               up, fire, adv, last_dup, last_ch, beat_last;
    logic               last_row, last_tile, last_grp, layer_wrap;
    logic [ADDR_W-1:0]  wo, ho, ch_off, row_off, col_off, beat_addr;
    logic [CH_W-1:0]    ch_left;
    logic [DIM_W-1:0]   col_left;
    logic [GRP_W-1:0]   geff, len;
    logic [LEN_W-1:0]   beat_len;

    assign up        = cfg_q.upsample;
    assign wo        = ADDR_W'(cfg_q.ofm_w) << up;
    assign ho        = ADDR_W'(cfg_q.ofm_h) << up;
    assign ch_left   = cfg_q.num_ch - chb_q;
    assign geff      = (CH_W'(cfg_q.grp_ch) < ch_left) ? cfg_q.grp_ch : GRP_W'(ch_left);
    assign col_left  = cfg_q.ofm_w - col0_q;
    assign len       = (DIM_W'(cfg_q.tile_w) < col_left) ? cfg_q.tile_w : GRP_W'(col_left);
    assign beat_len  = LEN_W'(len) << up;

    assign fire      = (state_q == ST_EMIT) && addr_ready;
    assign adv       = (state_q == ST_ADVANCE);
    assign last_dup  = !up || dup_q;
    assign last_ch   = (ch_q == geff - GRP_W'(1));
    assign beat_last = last_ch && last_dup;
    assign last_row  = (row_q == cfg_q.ofm_h - DIM_W'(1));
    assign last_tile = ({1'b0, col0_q} + (DIM_W+1)'(cfg_q.tile_w)) >= {1'b0, cfg_q.ofm_w};
    assign last_grp  = ({1'b0, chb_q} + (CH_W+1)'(cfg_q.grp_ch)) >= {1'b0, cfg_q.num_ch};
    assign layer_wrap = last_row && last_tile;

    ofm_addr_accum #(
        .ADDR_W (ADDR_W)
    ) u_accum (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (state_q == ST_SETUP),
        .ch_step_i    (fire && last_dup),
        .ch_rewind_i  (adv && !layer_wrap),
        .grp_commit_i (adv && layer_wrap),
        .row_step_i   (adv && !last_row),
        .row_clr_i    (adv && last_row),
        .col_step_i   (adv && last_row && !last_tile),
        .col_clr_i    (adv && layer_wrap),
        .plane_i      (plane_q),
        .row_inc_i    (wo << up),
        .col_inc_i    (ADDR_W'(cfg_q.tile_w) << up),
        .ch_off_o     (ch_off),
        .row_off_o    (row_off),
        .col_off_o    (col_off)
    );

    // The odd output row of an upsampled pair sits one output width further on.
    assign beat_addr = cfg_q.base_addr + ch_off + row_off + col_off + (dup_q ? wo : '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = ST_SETUP;
            ST_SETUP:     state_d = ST_WAIT_TILE;
            ST_WAIT_TILE: if (tile_valid) state_d = ST_EMIT;
            ST_EMIT:      if (fire && beat_last) state_d = ST_ADVANCE;
            ST_ADVANCE:   state_d = (layer_wrap && last_grp) ? ST_DONE : ST_WAIT_TILE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            plane_q <= '0;
            row_q   <= '0;
            col0_q  <= '0;
            chb_q   <= '0;
            ch_q    <= '0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                cfg_q <= '{base_addr: cfg_base_addr, ofm_w: cfg_ofm_w, ofm_h: cfg_ofm_h,
                           num_ch: cfg_num_ch, grp_ch: cfg_grp_ch, tile_w: cfg_tile_w,
                           upsample: cfg_upsample, addr_limit: cfg_addr_limit};
            end
            if (state_q == ST_SETUP) begin
                plane_q <= wo * ho;
                row_q   <= '0;
                col0_q  <= '0;
                chb_q   <= '0;
                ch_q    <= '0;
                dup_q   <= 1'b0;
            end
            if (fire) begin
                if (last_dup) begin
                    dup_q <= 1'b0;
                    ch_q  <= beat_last ? '0 : ch_q + GRP_W'(1);
                end else begin
                    dup_q <= 1'b1;
                end
            end
            if (adv) begin
                row_q <= last_row ? '0 : row_q + DIM_W'(1);
                if (last_row) begin
                    col0_q <= last_tile ? '0 : col0_q + DIM_W'(cfg_q.tile_w);
                    if (last_tile) begin
                        chb_q <= chb_q + CH_W'(cfg_q.grp_ch);
                    end
                end
            end
        end
    end

`ifdef OFM_ADDR_BOUNDS_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            err_q <= 1'b0;
        end else if (fire && (({1'b0, beat_addr} + (ADDR_W+1)'(beat_len)) >
                              {1'b0, cfg_q.addr_limit})) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_limit;
    assign unused_limit = ^cfg_q.addr_limit;
    assign err          = 1'b0;
`endif

    assign tile_ready = (state_q == ST_WAIT_TILE);
    assign addr_valid = (state_q == ST_EMIT);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign ofm_addr   = addr_valid ? beat_addr : '0;
    assign write_len  = addr_valid ? beat_len : '0;
    assign addr_last  = addr_valid && beat_last;

endmodule
`default_nettype wire

// File: tb/tb_ofm_write_addr_gen.sv
`default_nettype none
// Bench for ofm_write_addr_gen: vector table, hand-written corner sequences and
// randomized layers checked against a loop-nest reference model.
module tb_ofm_write_addr_gen;

    localparam int S  = 16;
    localparam int AW = 22;
    localparam int DW = 9;
    localparam int CW = 10;
    localparam int GW = $clog2(S) + 1;
    localparam int LW = $clog2(2 * S) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [DW-1:0] cfg_ofm_w = '0, cfg_ofm_h = '0;
    logic [CW-1:0] cfg_num_ch = '0;
    logic [GW-1:0] cfg_grp_ch = '0, cfg_tile_w = '0;
    logic          cfg_upsample = 1'b0;
    logic [AW-1:0] cfg_addr_limit = '0;
    logic          tile_valid = 1'b0, addr_ready = 1'b0;
    logic          tile_ready, addr_valid, addr_last, busy, done, err;
    logic [AW-1:0] ofm_addr;
    logic [LW-1:0] write_len;

    ofm_write_addr_gen dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_base_addr(cfg_base_addr), .cfg_ofm_w(cfg_ofm_w), .cfg_ofm_h(cfg_ofm_h),
        .cfg_num_ch(cfg_num_ch), .cfg_grp_ch(cfg_grp_ch), .cfg_tile_w(cfg_tile_w),
        .cfg_upsample(cfg_upsample), .cfg_addr_limit(cfg_addr_limit),
        .tile_valid(tile_valid), .tile_ready(tile_ready),
        .addr_valid(addr_valid), .addr_ready(addr_ready),
        .ofm_addr(ofm_addr), .write_len(write_len), .addr_last(addr_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {int base; int w; int h; int nch; int grp; int tw; int up; int limit;} tcfg_t;
    typedef struct {logic [AW-1:0] a; logic [LW-1:0] l; logic last;} beat_t;
    typedef struct {tcfg_t c; int mode; int n_beats; int n_tiles; int first_a; int last_a;} vec_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    int    exp_tiles, got_tiles, err_beat;
    logic  err_at_setup;
    int    total = 0;
    int    bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic tcfg_t mkc(int base, int w, int h, int nch, int grp, int tw, int up, int limit);
        tcfg_t c;
        c.base = base; c.w = w; c.h = h; c.nch = nch; c.grp = grp; c.tw = tw; c.up = up; c.limit = limit;
        return c;
    endfunction

    function automatic vec_t mkv(tcfg_t c, int mode, int nb, int nt, int fa, int la);
        vec_t v;
        v.c = c; v.mode = mode; v.n_beats = nb; v.n_tiles = nt; v.first_a = fa; v.last_a = la;
        return v;
    endfunction

    // Reference: plain loop nest over groups, column tiles, rows, channels, duplicates.
    task automatic model(input tcfg_t c);
        int wo, ho, plane, geff, len, ro;
        longint addr;
        beat_t b;
        exp_q.delete();
        exp_tiles = 0;
        wo = c.w * (1 + c.up);
        ho = c.h * (1 + c.up);
        plane = wo * ho;
        for (int g = 0; g * c.grp < c.nch; g++) begin
            geff = (c.nch - g * c.grp < c.grp) ? c.nch - g * c.grp : c.grp;
            for (int col0 = 0; col0 < c.w; col0 += c.tw) begin
                len = (c.w - col0 < c.tw) ? c.w - col0 : c.tw;
                for (int r = 0; r < c.h; r++) begin
                    exp_tiles++;
                    for (int ch = 0; ch < geff; ch++) begin
                        for (int d = 0; d <= c.up; d++) begin
                            ro = r * (1 + c.up) + d;
                            addr = longint'(c.base) + longint'(g * c.grp + ch) * plane
                                 + longint'(ro) * wo + longint'(col0 * (1 + c.up));
                            b.a = addr[AW-1:0];
                            b.l = LW'(len * (1 + c.up));
                            b.last = (ch == geff - 1) && (d == c.up);
                            exp_q.push_back(b);
                        end
                    end
                end
            end
        end
    endtask

    task automatic apply(input tcfg_t c);
        cfg_base_addr  = AW'(c.base);
        cfg_ofm_w      = DW'(c.w);
        cfg_ofm_h      = DW'(c.h);
        cfg_num_ch     = CW'(c.nch);
        cfg_grp_ch     = GW'(c.grp);
        cfg_tile_w     = GW'(c.tw);
        cfg_upsample   = (c.up != 0);
        cfg_addr_limit = AW'(c.limit);
    endtask

    // mode 0: ready always high; mode 1: ready 1-0-0-1; mode 2: random ready/valid.
    task automatic run_layer(input tcfg_t c, input int mode, input bit poke);
        beat_t      hold, b;
        bit         stalled, fin, poked;
        int         cyc, first_rdy;
        logic [3:0] pat;
        pat = 4'b1001;
        stalled = 0; fin = 0; poked = 0; cyc = 0; first_rdy = -1;
        hold = '{a: '0, l: '0, last: 1'b0};
        model(c);
        got_q.delete();
        got_tiles = 0;
        err_beat = -1;
        apply(c);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        err_at_setup = err;
        while (!fin && cyc < 20000) begin
            if (stalled) begin
                check("stall_valid", 64'(addr_valid), 64'(1));
                check("stall_beat", {ofm_addr, write_len, addr_last}, {hold.a, hold.l, hold.last});
            end
            if (err && err_beat < 0) err_beat = got_q.size();
            if (tile_ready && first_rdy < 0) first_rdy = cyc;
            if (done) fin = 1;
            tile_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            addr_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
            if (poke && !poked && tile_ready && cyc > 4) begin
                start = 1'b1;
                cfg_base_addr = AW'(c.base + 999);
                poked = 1;
            end else begin
                start = 1'b0;
            end
            if (tile_ready && tile_valid) got_tiles++;
            if (addr_valid && addr_ready) begin
                b.a = ofm_addr; b.l = write_len; b.last = addr_last;
                got_q.push_back(b);
            end
            stalled = addr_valid && !addr_ready;
            hold.a = ofm_addr; hold.l = write_len; hold.last = addr_last;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; tile_valid = 1'b0; addr_ready = 1'b0;
        check("layer_timeout", 64'(fin), 64'(1));
        check("done_then_idle", {done, busy}, 64'(0));
        check("first_tile_ready", 64'(first_rdy), 64'(1));
        check("beat_count", 64'(got_q.size()), 64'(exp_q.size()));
        check("tile_count", 64'(got_tiles), 64'(exp_tiles));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("beat%0d", i), {got_q[i].a, got_q[i].l, got_q[i].last},
                  {exp_q[i].a, exp_q[i].l, exp_q[i].last});
        end
    endtask

    initial begin
        vec_t  vt[6];
        tcfg_t basic, rc;
        int    ba[12], bl[12];
        int    n, cyc;
        basic = mkc(100, 5, 2, 3, 2, 4, 0, 118);
        vt[0] = mkv(basic, 0, 12, 8, 100, 129);
        vt[1] = mkv(mkc(0, 2, 1, 1, 1, 16, 1, 0), 0, 2, 1, 0, 4);
        vt[2] = mkv(mkc(0, 3, 3, 2, 16, 16, 0, 0), 1, 6, 3, 0, 15);
        vt[3] = mkv(mkc(4194303, 1, 1, 2, 1, 1, 0, 0), 2, 2, 2, 4194303, 0);
        vt[4] = mkv(mkc(10, 3, 2, 1, 1, 2, 1, 0), 0, 8, 4, 10, 32);
        vt[5] = mkv(basic, 1, 12, 8, 100, 129);
        ba = '{100, 110, 105, 115, 104, 114, 109, 119, 120, 125, 124, 129};
        bl = '{4, 4, 4, 4, 1, 1, 1, 1, 4, 4, 1, 1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {tile_ready, addr_valid, ofm_addr, write_len, addr_last, busy, done, err}, 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_layer(vt[i].c, vt[i].mode, 1'b0);
            check("vec_beats", 64'(got_q.size()), 64'(vt[i].n_beats));
            check("vec_tiles", 64'(got_tiles), 64'(vt[i].n_tiles));
            if (got_q.size() > 0) begin
                check("vec_first_addr", 64'(got_q[0].a), 64'(vt[i].first_a));
                check("vec_last_addr", 64'(got_q[got_q.size()-1].a), 64'(vt[i].last_a));
            end
        end

        run_layer(basic, 0, 1'b0);
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            check("basic_addr", 64'(got_q[i].a), 64'(ba[i]));
            check("basic_len", 64'(got_q[i].l), 64'(bl[i]));
        end
`ifdef OFM_ADDR_BOUNDS_CHECK_EN
        check("err_first_beat", 64'(err_beat), 64'(4));
        check("err_sticky", 64'(err), 64'(1));
`else
        check("err_never", 64'(err_beat), 64'(-1));
`endif

        // Reset while the third beat of the layer is on the bus.
        apply(basic);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef OFM_ADDR_BOUNDS_CHECK_EN
        check("err_cleared_by_start", 64'(err), 64'(0));
`endif
        tile_valid = 1'b1; addr_ready = 1'b1;
        n = 0; cyc = 0;
        while (cyc < 200) begin
            if (addr_valid) begin
                if (n == 2) break;
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_reached_beat3", 64'(n), 64'(2));
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_outputs", {tile_ready, addr_valid, ofm_addr, write_len, addr_last, busy, done, err}, 64'(0));
        rst = 1'b0; tile_valid = 1'b0; addr_ready = 1'b0;
        @(posedge clk); #1;
        run_layer(basic, 0, 1'b0);

        // start pulsed (with a different base) while waiting for a tile.
        run_layer(basic, 1, 1'b1);

        for (int k = 0; k < 6; k++) begin
            rc = mkc(int'($urandom_range(0, 4194303)), int'($urandom_range(1, 7)),
                     int'($urandom_range(1, 3)), int'($urandom_range(1, 20)),
                     int'($urandom_range(1, 16)), int'($urandom_range(1, 8)),
                     int'($urandom_range(0, 1)), 4194303);
            run_layer(rc, 2, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
